// File: rtl/sram_port_arbiter.sv
// Purpose: round-robin arbiter sharing one SRAM port between fill (F) and alpha-blend (A).
// Latency: enables high ACCESS_CYCLES cycles after the grant edge, ack one cycle later, one idle cycle after that.
// Backpressure: requesters hold req until their one-cycle ack; losers simply wait.
//
// Ports:
//   clk, n_rst                     clock and synchronous active-high reset
//   f_* / a_*                      per-requester req, write flag, address, write data, ack and last read data
//   read_enable, write_enable,
//   address, write_data, read_data SRAM pins
//   busy                           high while an access is in progress (state is not IDLE)
module sram_port_arbiter #(
  parameter int ADDR_W        = 24,
  parameter int DATA_W        = 1536,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              f_req,
  input  logic              f_write,
  input  logic [ADDR_W-1:0] f_address,
  input  logic [DATA_W-1:0] f_write_data,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_read_data,
  input  logic              a_req,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_write_data,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_read_data,
  output logic              read_enable,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ptr;    // requester preferred on a tie: 0 = F, 1 = A
  logic              r_win;    // current winner: 0 = F, 1 = A
  logic              r_re;
  logic              r_we;
  logic              r_f_ack;
  logic              r_a_ack;
  logic [ADDR_W-1:0] r_addr;   // doubles as the address latch while in ACCESS
  logic [DATA_W-1:0] r_wdata;  // doubles as the write-data latch while in ACCESS
  logic [DATA_W-1:0] r_f_rd;
  logic [DATA_W-1:0] r_a_rd;

  // A wins when it is the only requester, or when both ask and the pointer names A.
  logic w_grant_a;
  assign w_grant_a = a_req & (~f_req | r_ptr);

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= 1'b0;
      r_win   <= 1'b0;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_f_ack <= 1'b0;
      r_a_ack <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_f_rd  <= '0;
      r_a_rd  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (f_req | a_req) begin
            r_win <= w_grant_a;
            if (w_grant_a) begin
              r_re    <= ~a_write;
              r_we    <= a_write;
              r_addr  <= a_address;
              r_wdata <= a_write ? a_write_data : '0;
            end else begin
              r_re    <= ~f_write;
              r_we    <= f_write;
              r_addr  <= f_address;
              r_wdata <= f_write ? f_write_data : '0;
            end
            r_cnt   <= CNT_W'(ACCESS_CYCLES - 1);
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            // Last enable cycle: the SRAM read result is valid on this edge.
            if (r_re) begin
              if (r_win) r_a_rd <= read_data;
              else       r_f_rd <= read_data;
            end
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_f_ack <= ~r_win;
            r_a_ack <= r_win;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          r_f_ack <= 1'b0;
          r_a_ack <= 1'b0;
          r_ptr   <= ~r_win;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign f_ack        = r_f_ack;
  assign a_ack        = r_a_ack;
  assign f_read_data  = r_f_rd;
  assign a_read_data  = r_a_rd;
  assign read_enable  = r_re;
  assign write_enable = r_we;
  assign address      = r_addr;
  assign write_data   = r_wdata;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int AW = 24;
  localparam int DW = 1536;
  localparam int AC = 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          f_req, f_write, a_req, a_write;
  logic [AW-1:0] f_address, a_address;
  logic [DW-1:0] f_write_data, a_write_data, read_data;
  logic          f_ack, a_ack, read_enable, write_enable, busy;
  logic [DW-1:0] f_read_data, a_read_data, write_data;
  logic [AW-1:0] address;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .n_rst(n_rst),
    .f_req(f_req), .f_write(f_write), .f_address(f_address), .f_write_data(f_write_data),
    .f_ack(f_ack), .f_read_data(f_read_data),
    .a_req(a_req), .a_write(a_write), .a_address(a_address), .a_write_data(a_write_data),
    .a_ack(a_ack), .a_read_data(a_read_data),
    .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .write_data(write_data), .read_data(read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (low 128 bits shown)", nm, act[127:0], exp[127:0]);
    end
  endfunction

  // ---------------- behavioural model: a schedule of expected output cycles ----------------
  typedef struct {
    bit            re, we, fack, aack, busy, cap_f, cap_a;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } ent_t;

  ent_t          sched[$];
  ent_t          cur;
  bit            m_ptr;
  logic [DW-1:0] m_frd, m_ard;
  bit            ack_who[$];   // 0 = F, 1 = A
  int            ack_cyc[$];

  function automatic ent_t idle_e();
    ent_t e;
    e.re = 0; e.we = 0; e.fack = 0; e.aack = 0; e.busy = 0; e.cap_f = 0; e.cap_a = 0;
    e.addr = '0; e.wd = '0;
    return e;
  endfunction

  task automatic model_step();
    ent_t          e;
    bit            w, wr;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    if (n_rst) begin
      sched.delete();
      m_ptr = 0; m_frd = '0; m_ard = '0;
      cur = idle_e();
    end else if (sched.size() != 0) begin
      cur = sched.pop_front();
      if (cur.cap_f) m_frd = read_data;
      if (cur.cap_a) m_ard = read_data;
    end else if (f_req || a_req) begin
      w     = (f_req && a_req) ? m_ptr : a_req;
      m_ptr = !w;
      wr    = w ? a_write : f_write;
      ad    = w ? a_address : f_address;
      wd    = wr ? (w ? a_write_data : f_write_data) : '0;
      for (int i = 0; i < AC; i++) begin
        e = idle_e(); e.re = !wr; e.we = wr; e.addr = ad; e.wd = wd; e.busy = 1;
        sched.push_back(e);
      end
      e = idle_e(); e.busy = 1; e.fack = !w; e.aack = w; e.cap_f = !w && !wr; e.cap_a = w && !wr;
      sched.push_back(e);
      sched.push_back(idle_e());
      cur = sched.pop_front();
    end else begin
      cur = idle_e();
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    cyc++;
    chk("f_ack",        DW'(f_ack),        DW'(cur.fack));
    chk("a_ack",        DW'(a_ack),        DW'(cur.aack));
    chk("read_enable",  DW'(read_enable),  DW'(cur.re));
    chk("write_enable", DW'(write_enable), DW'(cur.we));
    chk("busy",         DW'(busy),         DW'(cur.busy));
    chk("address",      DW'(address),      DW'(cur.addr));
    chk("write_data",   write_data,        cur.wd);
    chk("f_read_data",  f_read_data,       m_frd);
    chk("a_read_data",  a_read_data,       m_ard);
    if (f_ack === 1'b1) begin ack_who.push_back(1'b0); ack_cyc.push_back(cyc); end
    if (a_ack === 1'b1) begin ack_who.push_back(1'b1); ack_cyc.push_back(cyc); end
  end

  // ---------------- directed stimulus with hand-computed expectations ----------------
  task automatic nc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_f_ack"}, DW'(f_ack), '0);
    chk({tag, "_a_ack"}, DW'(a_ack), '0);
    chk({tag, "_re"},    DW'(read_enable), '0);
    chk({tag, "_we"},    DW'(write_enable), '0);
    chk({tag, "_busy"},  DW'(busy), '0);
    chk({tag, "_addr"},  DW'(address), '0);
    chk({tag, "_wdata"}, write_data, '0);
    chk({tag, "_frd"},   f_read_data, '0);
    chk({tag, "_ard"},   a_read_data, '0);
  endtask

  task automatic rand_inputs();
    f_req = 1'($urandom); a_req = 1'($urandom);
    f_write = 1'($urandom); a_write = 1'($urandom);
    f_address = AW'($urandom); a_address = AW'($urandom);
    f_write_data = {48{$urandom}}; a_write_data = {48{$urandom}};
    read_data = {48{$urandom}};
  endtask

  logic [DW-1:0] P, PF, PA, JUNK;
  int            k;

  initial begin
    P    = {48{32'hA5C3_0F96}};
    PF   = {48{32'h1111_F00F}};
    PA   = {48{32'h2222_A00A}};
    JUNK = {48{32'hDEAD_BEEF}};

    // 1. reset with random inputs
    n_rst = 1'b1;
    rand_inputs();
    nc(1); chk_zero("t1_rst0");
    rand_inputs();
    nc(1); chk_zero("t1_rst1");
    n_rst = 1'b0; f_req = 0; a_req = 0;
    nc(1); chk_zero("t1_post");

    // 2. single fill read
    f_req = 1; f_write = 0; f_address = 24'h00_1234; read_data = P;
    nc(1); chk("t2_re1", DW'(read_enable), DW'(1)); chk("t2_addr1", DW'(address), DW'(24'h001234));
    nc(1); chk("t2_re2", DW'(read_enable), DW'(1)); chk("t2_addr2", DW'(address), DW'(24'h001234));
    nc(1); chk("t2_re3", DW'(read_enable), DW'(0)); chk("t2_fack", DW'(f_ack), DW'(1));
    chk("t2_frd", f_read_data, P); chk("t2_aack", DW'(a_ack), DW'(0));
    f_req = 0;
    nc(1); chk("t2_fack_pulse", DW'(f_ack), DW'(0)); chk("t2_idle", DW'(busy), DW'(0));

    // 3. simultaneous first requests right after reset
    n_rst = 1;
    nc(1);
    n_rst = 0; ack_who.delete(); ack_cyc.delete();
    f_req = 1; f_write = 0; f_address = 24'h00F00F;
    a_req = 1; a_write = 0; a_address = 24'h00A00A; read_data = PF;
    nc(1); chk("t3_f_addr", DW'(address), DW'(24'h00F00F)); chk("t3_f_re", DW'(read_enable), DW'(1));
    nc(1);
    nc(1); chk("t3_fack", DW'(f_ack), DW'(1)); chk("t3_frd", f_read_data, PF);
    f_req = 0; read_data = PA;
    nc(1);
    nc(1); chk("t3_a_addr", DW'(address), DW'(24'h00A00A)); chk("t3_a_re", DW'(read_enable), DW'(1));
    nc(1);
    nc(1); chk("t3_aack", DW'(a_ack), DW'(1)); chk("t3_ard", a_read_data, PA);
    a_req = 0;
    chk("t3_nacks", DW'(ack_who.size()), DW'(2));
    if (ack_who.size() == 2) begin
      chk("t3_first_F", DW'(ack_who[0]), DW'(0));
      chk("t3_then_A",  DW'(ack_who[1]), DW'(1));
    end
    nc(1);

    // 4. continuous contention for 8 accesses
    ack_who.delete(); ack_cyc.delete();
    f_req = 1; f_write = 1; f_address = 24'h000100; f_write_data = {48{32'h5A5A_5A5A}};
    a_req = 1; a_write = 0; a_address = 24'h000200;
    k = 0;
    while (ack_who.size() < 8 && k < 100) begin nc(1); k++; end
    f_req = 0; a_req = 0;
    chk("t4_nacks", DW'(ack_who.size()), DW'(8));
    for (int i = 0; i < ack_who.size(); i++) begin
      chk($sformatf("t4_who%0d", i), DW'(ack_who[i]), DW'(i % 2));
      if (i > 0) chk($sformatf("t4_gap%0d", i), DW'(ack_cyc[i] - ack_cyc[i-1]), DW'(4));
    end
    nc(1);

    // 5. alpha write
    a_req = 1; a_write = 1; a_address = 24'hABCDEF; a_write_data = '1; read_data = JUNK;
    nc(1); chk("t5_we1", DW'(write_enable), DW'(1)); chk("t5_re1", DW'(read_enable), DW'(0));
    chk("t5_addr1", DW'(address), DW'(24'hABCDEF)); chk("t5_wd1", write_data, '1);
    nc(1); chk("t5_we2", DW'(write_enable), DW'(1)); chk("t5_wd2", write_data, '1);
    nc(1); chk("t5_aack", DW'(a_ack), DW'(1)); chk("t5_ard_kept", a_read_data, PA);
    chk("t5_we_off", DW'(write_enable), DW'(0));
    a_req = 0;
    nc(1);

    // 6. reset mid-access: a lone F access first leaves the pointer on A
    f_req = 1; f_write = 0; f_address = 24'h000333; read_data = PF;
    nc(3); chk("t6_pre_fack", DW'(f_ack), DW'(1));
    f_req = 0;
    nc(1);
    f_req = 1; a_req = 1; a_write = 0; f_address = 24'h000444; a_address = 24'h000555;
    nc(1); chk("t6_a_wins", DW'(address), DW'(24'h000555));
    nc(1); n_rst = 1;
    nc(1); chk("t6_re_drop", DW'(read_enable), DW'(0)); chk("t6_noack_f", DW'(f_ack), DW'(0));
    chk("t6_noack_a", DW'(a_ack), DW'(0)); chk("t6_busy", DW'(busy), DW'(0));
    n_rst = 0;
    nc(1); chk("t6_f_first", DW'(address), DW'(24'h000444)); chk("t6_f_re", DW'(read_enable), DW'(1));
    nc(2); chk("t6_fack", DW'(f_ack), DW'(1));
    f_req = 0;
    nc(4); chk("t6_aack", DW'(a_ack), DW'(1));
    a_req = 0;
    nc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 100000", $time);
    $fatal(1);
  end

endmodule
